// File: rtl/button_event_arbiter.sv
// -----------------------------------------------------------------------------
// button_event_arbiter
//
// Player-input front end for the LED game. Each raw button is synchronised by
// a 2-flop chain, debounced by a per-button stability counter, and every
// accepted level change becomes a press or release event. Events wait in a
// per-button pending slot and are granted round-robin, at most one per cycle,
// into a small first-word-fall-through FIFO that is read over valid/ready.
//
// Ports
//   clk           system clock, all logic on the rising edge
//   reset         synchronous active-high reset
//   buttons       raw asynchronous button levels, 1 = pressed
//   enable        1 = turn debounced transitions into events, 0 = drop them
//   flush         synchronous clear of the FIFO and the pending slots
//   event_valid   FIFO head is valid (registered)
//   event_ready   consumer takes the head this cycle
//   event_button  button index of the head event (registered)
//   event_press   1 = press, 0 = release, for the head event (registered)
//   fifo_count    FIFO occupancy (registered)
//   overflow      sticky: a pending event was overwritten before it was queued
// -----------------------------------------------------------------------------
module button_event_arbiter #(
  parameter int NUM_BUTTONS     = 4,
  parameter int IDX_W           = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int FIFO_DEPTH      = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_BUTTONS-1:0]        buttons,
  input  logic                          enable,
  input  logic                          flush,
  output logic                          event_valid,
  input  logic                          event_ready,
  output logic [IDX_W-1:0]              event_button,
  output logic                          event_press,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int ENT_W  = IDX_W + 1;
  localparam int EXT_N  = 1 << IDX_W;
  localparam int DB_W   = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  localparam logic [DB_W-1:0]  DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [DB_W-1:0]  DB_ONE    = DB_W'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(0);
  localparam logic [IDX_W:0]   NB_WIDE   = (IDX_W + 1)'(NUM_BUTTONS);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_BUTTONS - 1);
  localparam logic [IDX_W-1:0] IDX_ZERO  = IDX_W'(0);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

  // Round-robin pointer advance: one past the granted button, wrapping.
  function automatic logic [IDX_W-1:0] rr_after(input logic [IDX_W-1:0] grant);
    if (grant == IDX_LAST) begin
      return IDX_ZERO;
    end else begin
      return grant + IDX_ONE;
    end
  endfunction

  // Synchroniser and debouncer state
  logic [NUM_BUTTONS-1:0] meta_r;
  logic [NUM_BUTTONS-1:0] sync_r;
  logic [NUM_BUTTONS-1:0] stable_r;
  logic [DB_W-1:0]        db_cnt_r [NUM_BUTTONS];
  logic [NUM_BUTTONS-1:0] trans_s;

  // Pending stage and arbiter
  logic [NUM_BUTTONS-1:0] pend_r;
  logic [NUM_BUTTONS-1:0] kind_r;
  logic [IDX_W-1:0]       rr_ptr_r;
  logic                   overflow_r;
  logic [EXT_N-1:0]       pend_ext_s;
  logic [EXT_N-1:0]       kind_ext_s;
  logic [EXT_N-1:0]       grant_oh_ext_s;
  logic [NUM_BUTTONS-1:0] grant_oh_s;
  logic [IDX_W:0]         cand_sum_s;
  logic                   found_s;
  logic [IDX_W-1:0]       grant_idx_s;

  // FIFO
  logic [ENT_W-1:0]       mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_r;
  logic [PTR_W-1:0]       rd_ptr_r;
  logic [CNT_W-1:0]       count_r;
  logic                   valid_r;
  logic [ENT_W-1:0]       head_r;
  logic                   pop_s;
  logic                   push_s;
  logic [ENT_W-1:0]       push_data_s;
  logic [PTR_W-1:0]       rd_n_s;
  logic [CNT_W-1:0]       count_n_s;
  logic [ENT_W-1:0]       head_n_s;

  // Two-flop synchroniser chain per button.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta_r <= '0;
      sync_r <= '0;
    end else begin
      meta_r <= buttons;
      sync_r <= meta_r;
    end
  end

  // A transition fires on the edge where a differing level has been seen for
  // DEBOUNCE_CYCLES consecutive cycles.
  always_comb begin
    trans_s = '0;
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      trans_s[i] = (sync_r[i] != stable_r[i]) && (db_cnt_r[i] == DB_LAST);
    end
  end

  // Debounce counters and accepted stable levels.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_BUTTONS; i++) begin
      if (reset) begin
        stable_r[i] <= 1'b0;
        db_cnt_r[i] <= '0;
      end else if (sync_r[i] == stable_r[i]) begin
        db_cnt_r[i] <= '0;
      end else if (db_cnt_r[i] == DB_LAST) begin
        stable_r[i] <= ~stable_r[i];
        db_cnt_r[i] <= '0;
      end else begin
        db_cnt_r[i] <= db_cnt_r[i] + DB_ONE;
      end
    end
  end

  // Round-robin search: first pending button at or after rr_ptr, wrapping.
  always_comb begin
    pend_ext_s                   = '0;
    pend_ext_s[NUM_BUTTONS-1:0]  = pend_r;
    kind_ext_s                   = '0;
    kind_ext_s[NUM_BUTTONS-1:0]  = kind_r;
    found_s                      = 1'b0;
    grant_idx_s                  = '0;
    cand_sum_s                   = '0;
    for (int k = 0; k < NUM_BUTTONS; k++) begin
      cand_sum_s = {1'b0, rr_ptr_r} + (IDX_W + 1)'(k);
      if (cand_sum_s >= NB_WIDE) begin
        cand_sum_s = cand_sum_s - NB_WIDE;
      end else begin
        cand_sum_s = cand_sum_s;
      end
      if (!found_s && pend_ext_s[cand_sum_s[IDX_W-1:0]]) begin
        found_s     = 1'b1;
        grant_idx_s = cand_sum_s[IDX_W-1:0];
      end else begin
        // an earlier candidate already holds the grant
        found_s     = found_s;
      end
    end
  end

  // Handshake, grant qualification and next FIFO state. A full FIFO still
  // accepts a push on a cycle that also pops.
  always_comb begin
    pop_s          = valid_r & event_ready;
    push_s         = found_s & ((count_r != CNT_FULL) | pop_s);
    grant_oh_ext_s = '0;
    if (push_s) begin
      grant_oh_ext_s[grant_idx_s] = 1'b1;
    end else begin
      grant_oh_ext_s = '0;
    end
    grant_oh_s  = grant_oh_ext_s[NUM_BUTTONS-1:0];
    push_data_s = {grant_idx_s, kind_ext_s[grant_idx_s]};

    if (pop_s) begin
      rd_n_s = rd_ptr_r + PTR_ONE;
    end else begin
      rd_n_s = rd_ptr_r;
    end
    count_n_s = count_r + CNT_W'(push_s) - CNT_W'(pop_s);

    // The new head is the entry being written this edge when the read
    // pointer lands on the write slot (empty FIFO, or last entry popped).
    if (push_s && (rd_n_s == wr_ptr_r)) begin
      head_n_s = push_data_s;
    end else begin
      head_n_s = mem_r[rd_n_s];
    end
  end

  // Pending slots, round-robin pointer and sticky overflow.
  always_ff @(posedge clk) begin
    if (reset) begin
      pend_r     <= '0;
      kind_r     <= '0;
      rr_ptr_r   <= '0;
      overflow_r <= 1'b0;
    end else if (flush) begin
      // transitions landing on a flush edge are dropped with the queue
      pend_r     <= '0;
    end else begin
      for (int i = 0; i < NUM_BUTTONS; i++) begin
        if (trans_s[i] && enable) begin
          // a new transition wins over a same-edge grant of the old entry
          pend_r[i] <= 1'b1;
          kind_r[i] <= ~stable_r[i];
          if (pend_r[i] && !grant_oh_s[i]) begin
            overflow_r <= 1'b1;
          end else begin
            overflow_r <= overflow_r | 1'b0;
          end
        end else if (grant_oh_s[i]) begin
          pend_r[i] <= 1'b0;
        end else begin
          pend_r[i] <= pend_r[i];
        end
      end
      if (push_s) begin
        rr_ptr_r <= rr_after(grant_idx_s);
      end else begin
        rr_ptr_r <= rr_ptr_r;
      end
    end
  end

  // FIFO storage; contents need no reset because occupancy gates visibility.
  always_ff @(posedge clk) begin
    if (push_s && !flush && !reset) begin
      mem_r[wr_ptr_r] <= push_data_s;
    end
  end

  // FIFO pointers, occupancy and the registered head outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      valid_r  <= 1'b0;
      head_r   <= '0;
    end else if (flush) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
      valid_r  <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      rd_ptr_r <= rd_n_s;
      count_r  <= count_n_s;
      valid_r  <= (count_n_s != CNT_ZERO);
      // an empty FIFO keeps showing the last head
      if (count_n_s != CNT_ZERO) begin
        head_r <= head_n_s;
      end
    end
  end

  assign event_valid  = valid_r;
  assign event_button = head_r[ENT_W-1:1];
  assign event_press  = head_r[0];
  assign fifo_count   = count_r;
  assign overflow     = overflow_r;

endmodule
